// File: rtl/mc_controller.sv
// mc_controller: multicycle RISC-V main control FSM; clk/reset in, op/Zero/mem_ready in, datapath enables/selects, ImmSrc, instr_done, illegal, state out
module mc_controller #(
  parameter bit SUPPORT_LUI     = 1'b1,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3, MEMWB = 4'd4,
    MEMWRITE = 4'd5, EXECUTER = 4'd6, EXECUTEI = 4'd7, ALUWB = 4'd8, BEQ = 4'd9,
    JAL = 4'd10, LUI = 4'd11, TRAP = 4'd12
  } state_t;
  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
    OP_I = 7'b0010011, OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111, OP_LUI = 7'b0110111;
  state_t state_q, state_d, dec_next;
  logic illegal_q, illegal_d, dec_illegal;
  logic pc_we, mem_we, ir_we, reg_we;
  always_comb begin
    dec_illegal = 1'b0;
    dec_next = FETCH;
    case (op)
      OP_LW, OP_SW: dec_next = MEMADR;
      OP_R:         dec_next = EXECUTER;
      OP_I:         dec_next = EXECUTEI;
      OP_BEQ:       dec_next = BEQ;
      OP_JAL:       dec_next = JAL;
      OP_LUI:       dec_next = SUPPORT_LUI ? LUI : (TRAP_ON_ILLEGAL ? TRAP : FETCH);
      default:      dec_next = TRAP_ON_ILLEGAL ? TRAP : FETCH;
    endcase
    dec_illegal = !(op == OP_LW || op == OP_SW || op == OP_R || op == OP_I ||
                    op == OP_BEQ || op == OP_JAL || (SUPPORT_LUI && op == OP_LUI));
  end
  always_comb begin
    ImmSrc = op == OP_SW ? 3'b001 : op == OP_BEQ ? 3'b010 : op == OP_JAL ? 3'b011 :
             (SUPPORT_LUI && op == OP_LUI) ? 3'b100 : 3'b000;
  end
  always_comb begin
    state_d    = state_q;
    illegal_d  = illegal_q;
    pc_we      = 1'b0;
    mem_we     = 1'b0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    instr_done = 1'b0;
    case (state_q)
      FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        ir_we     = mem_ready;
        pc_we     = mem_ready;
        state_d   = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b01;
        state_d    = dec_next;
        illegal_d  = illegal_q | dec_illegal;
        instr_done = dec_illegal & !TRAP_ON_ILLEGAL;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = op == OP_LW ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        ResultSrc  = 2'b01;
        reg_we     = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      MEMWRITE: begin
        AdrSrc     = 1'b1;
        mem_we     = 1'b1;
        instr_done = mem_ready;
        state_d    = mem_ready ? FETCH : MEMWRITE;
      end
      EXECUTER: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
        state_d = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
        state_d = ALUWB;
      end
      ALUWB: begin
        reg_we     = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      BEQ: begin
        ALUSrcA    = 2'b10;
        ALUOp      = 2'b01;
        pc_we      = Zero;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        pc_we   = 1'b1;
        state_d = ALUWB;
      end
      LUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
        state_d = ALUWB;
      end
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end
  // reset is async, so FETCH's mem_ready-driven enables must be masked while it is held
  assign PCWrite  = pc_we & ~reset;
  assign MemWrite = mem_we & ~reset;
  assign IRWrite  = ir_we & ~reset;
  assign RegWrite = reg_we & ~reset;
  assign illegal  = illegal_q;
  assign state    = state_q;
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed self-checking bench for mc_controller
module tb_mc_controller;
  typedef struct {
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [2:0] ImmSrc;
    logic       instr_done, illegal;
    logic [3:0] state;
  } outs_t;
  logic clk = 1'b0, reset = 1'b1, Zero = 1'b0, mem_ready = 1'b0;
  logic [6:0] op = 7'b0;
  outs_t o0, o1, o2;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  mc_controller #(.SUPPORT_LUI(1'b1), .TRAP_ON_ILLEGAL(1'b1)) dut0 (
    .clk(clk), .reset(reset), .op(op), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(o0.PCWrite), .AdrSrc(o0.AdrSrc), .MemWrite(o0.MemWrite), .IRWrite(o0.IRWrite),
    .RegWrite(o0.RegWrite), .ResultSrc(o0.ResultSrc), .ALUSrcA(o0.ALUSrcA), .ALUSrcB(o0.ALUSrcB),
    .ALUOp(o0.ALUOp), .ImmSrc(o0.ImmSrc), .instr_done(o0.instr_done), .illegal(o0.illegal),
    .state(o0.state));
  mc_controller #(.SUPPORT_LUI(1'b1), .TRAP_ON_ILLEGAL(1'b0)) dut1 (
    .clk(clk), .reset(reset), .op(op), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(o1.PCWrite), .AdrSrc(o1.AdrSrc), .MemWrite(o1.MemWrite), .IRWrite(o1.IRWrite),
    .RegWrite(o1.RegWrite), .ResultSrc(o1.ResultSrc), .ALUSrcA(o1.ALUSrcA), .ALUSrcB(o1.ALUSrcB),
    .ALUOp(o1.ALUOp), .ImmSrc(o1.ImmSrc), .instr_done(o1.instr_done), .illegal(o1.illegal),
    .state(o1.state));
  mc_controller #(.SUPPORT_LUI(1'b0), .TRAP_ON_ILLEGAL(1'b1)) dut2 (
    .clk(clk), .reset(reset), .op(op), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(o2.PCWrite), .AdrSrc(o2.AdrSrc), .MemWrite(o2.MemWrite), .IRWrite(o2.IRWrite),
    .RegWrite(o2.RegWrite), .ResultSrc(o2.ResultSrc), .ALUSrcA(o2.ALUSrcA), .ALUSrcB(o2.ALUSrcB),
    .ALUOp(o2.ALUOp), .ImmSrc(o2.ImmSrc), .instr_done(o2.instr_done), .illegal(o2.illegal),
    .state(o2.state));
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    mem_ready = 1'b1;
    op = 7'b0000011;
    tick();
    n_cmp++;
    if (o0.state !== 4'd0 || o0.illegal !== 1'b0 || o0.IRWrite !== 1'b0 || o0.PCWrite !== 1'b0 ||
        o0.MemWrite !== 1'b0 || o0.RegWrite !== 1'b0 || o0.instr_done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: state=%0d illegal=%b IR=%b PC=%b MW=%b RW=%b done=%b, need 0 all",
               o0.state, o0.illegal, o0.IRWrite, o0.PCWrite, o0.MemWrite, o0.RegWrite, o0.instr_done);
    end
    reset = 1'b0;
    #1;
  endtask
  task automatic test_rtype();
    logic [3:0] st[5] = '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0};
    logic rw[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int done_cnt = 0;
    do_reset();
    op = 7'b0110011;
    mem_ready = 1'b0;
    #1;
    n_cmp++;
    if (o0.IRWrite !== 1'b0 || o0.PCWrite !== 1'b0) begin
      n_bad++;
      $display("FAIL fetch_wait_enables: IR=%b PC=%b, need 0 0", o0.IRWrite, o0.PCWrite);
    end
    tick();
    n_cmp++;
    if (o0.state !== 4'd0) begin
      n_bad++;
      $display("FAIL fetch_hold: state=%0d, need 0", o0.state);
    end
    mem_ready = 1'b1;
    #1;
    n_cmp++;
    if (o0.IRWrite !== 1'b1 || o0.PCWrite !== 1'b1 || o0.ALUSrcB !== 2'b10 || o0.ResultSrc !== 2'b10) begin
      n_bad++;
      $display("FAIL fetch_outputs: IR=%b PC=%b B=%b RS=%b, need 1 1 10 10",
               o0.IRWrite, o0.PCWrite, o0.ALUSrcB, o0.ResultSrc);
    end
    for (int i = 0; i < 5; i++) begin
      done_cnt += int'(o0.instr_done);
      n_cmp++;
      if (o0.state !== st[i] || o0.RegWrite !== rw[i]) begin
        n_bad++;
        $display("FAIL rtype_step%0d: state=%0d RW=%b, need %0d %b", i, o0.state, o0.RegWrite, st[i], rw[i]);
      end
      if (i == 2) begin
        n_cmp++;
        if (o0.ALUSrcA !== 2'b10 || o0.ALUSrcB !== 2'b00 || o0.ALUOp !== 2'b10) begin
          n_bad++;
          $display("FAIL executer_sel: A=%b B=%b op=%b, need 10 00 10", o0.ALUSrcA, o0.ALUSrcB, o0.ALUOp);
        end
      end
      if (i < 4) tick();
    end
    n_cmp++;
    if (done_cnt != 1) begin
      n_bad++;
      $display("FAIL rtype_done_count: got %0d, need 1", done_cnt);
    end
  endtask
  task automatic test_lw();
    do_reset();
    op = 7'b0000011;
    mem_ready = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (o0.state !== 4'd2 || o0.ALUSrcA !== 2'b10 || o0.ALUSrcB !== 2'b01) begin
      n_bad++;
      $display("FAIL lw_memadr: state=%0d A=%b B=%b, need 2 10 01", o0.state, o0.ALUSrcA, o0.ALUSrcB);
    end
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) begin
        mem_ready = 1'b1;
        #1;
      end
      n_cmp++;
      if (o0.state !== 4'd3 || o0.AdrSrc !== 1'b1 || o0.RegWrite !== 1'b0) begin
        n_bad++;
        $display("FAIL lw_memread%0d: state=%0d Adr=%b RW=%b, need 3 1 0", i, o0.state, o0.AdrSrc, o0.RegWrite);
      end
    end
    tick();
    n_cmp++;
    if (o0.state !== 4'd4 || o0.RegWrite !== 1'b1 || o0.ResultSrc !== 2'b01 || o0.instr_done !== 1'b1) begin
      n_bad++;
      $display("FAIL lw_memwb: state=%0d RW=%b RS=%b done=%b, need 4 1 01 1",
               o0.state, o0.RegWrite, o0.ResultSrc, o0.instr_done);
    end
    tick();
    n_cmp++;
    if (o0.state !== 4'd0) begin
      n_bad++;
      $display("FAIL lw_return: state=%0d, need 0", o0.state);
    end
  endtask
  task automatic test_beq();
    do_reset();
    op = 7'b1100011;
    mem_ready = 1'b1;
    Zero = 1'b1;
    tick();
    n_cmp++;
    if (o0.ImmSrc !== 3'b010) begin
      n_bad++;
      $display("FAIL beq_immsrc: got %b, need 010", o0.ImmSrc);
    end
    tick();
    n_cmp++;
    if (o0.state !== 4'd9 || o0.PCWrite !== 1'b1 || o0.ALUOp !== 2'b01 || o0.instr_done !== 1'b1) begin
      n_bad++;
      $display("FAIL beq_taken: state=%0d PC=%b op=%b done=%b, need 9 1 01 1",
               o0.state, o0.PCWrite, o0.ALUOp, o0.instr_done);
    end
    Zero = 1'b0;
    #1;
    n_cmp++;
    if (o0.PCWrite !== 1'b0) begin
      n_bad++;
      $display("FAIL beq_not_taken: PC=%b, need 0", o0.PCWrite);
    end
    tick();
    n_cmp++;
    if (o0.state !== 4'd0) begin
      n_bad++;
      $display("FAIL beq_return: state=%0d, need 0", o0.state);
    end
  endtask
  task automatic test_sw();
    do_reset();
    op = 7'b0100011;
    mem_ready = 1'b1;
    tick();
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) begin
        mem_ready = 1'b1;
        #1;
      end
      n_cmp++;
      if (o0.state !== 4'd5 || o0.MemWrite !== 1'b1 || o0.AdrSrc !== 1'b1 ||
          o0.ImmSrc !== 3'b001 || o0.instr_done !== (i == 2)) begin
        n_bad++;
        $display("FAIL sw_memwrite%0d: state=%0d MW=%b Adr=%b imm=%b done=%b, need 5 1 1 001 %b",
                 i, o0.state, o0.MemWrite, o0.AdrSrc, o0.ImmSrc, o0.instr_done, i == 2);
      end
    end
    tick();
    n_cmp++;
    if (o0.state !== 4'd0 || o0.MemWrite !== 1'b0) begin
      n_bad++;
      $display("FAIL sw_return: state=%0d MW=%b, need 0 0", o0.state, o0.MemWrite);
    end
  endtask
  task automatic test_jal_lui();
    do_reset();
    op = 7'b1101111;
    mem_ready = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (o0.state !== 4'd10 || o0.PCWrite !== 1'b1 || o0.ALUSrcA !== 2'b01 || o0.ALUSrcB !== 2'b10 ||
        o0.ImmSrc !== 3'b011) begin
      n_bad++;
      $display("FAIL jal: state=%0d PC=%b A=%b B=%b imm=%b, need 10 1 01 10 011",
               o0.state, o0.PCWrite, o0.ALUSrcA, o0.ALUSrcB, o0.ImmSrc);
    end
    tick();
    tick();
    op = 7'b0110111;
    tick();
    tick();
    n_cmp++;
    if (o0.state !== 4'd11 || o0.ALUSrcA !== 2'b11 || o0.ALUSrcB !== 2'b01 || o0.ImmSrc !== 3'b100 ||
        o0.PCWrite !== 1'b0) begin
      n_bad++;
      $display("FAIL lui: state=%0d A=%b B=%b imm=%b PC=%b, need 11 11 01 100 0",
               o0.state, o0.ALUSrcA, o0.ALUSrcB, o0.ImmSrc, o0.PCWrite);
    end
    tick();
    n_cmp++;
    if (o0.state !== 4'd8 || o0.RegWrite !== 1'b1) begin
      n_bad++;
      $display("FAIL lui_aluwb: state=%0d RW=%b, need 8 1", o0.state, o0.RegWrite);
    end
  endtask
  task automatic test_illegal();
    do_reset();
    op = 7'b0000000;
    mem_ready = 1'b1;
    tick();
    n_cmp++;
    if (o1.state !== 4'd1 || o1.instr_done !== 1'b1 || o0.instr_done !== 1'b0) begin
      n_bad++;
      $display("FAIL illegal_decode_done: skip state=%0d done=%b trap done=%b, need 1 1 0",
               o1.state, o1.instr_done, o0.instr_done);
    end
    tick();
    n_cmp++;
    if (o0.state !== 4'd12 || o0.illegal !== 1'b1 || o1.state !== 4'd0 || o1.illegal !== 1'b1) begin
      n_bad++;
      $display("FAIL illegal_next: trap state=%0d ill=%b skip state=%0d ill=%b, need 12 1 0 1",
               o0.state, o0.illegal, o1.state, o1.illegal);
    end
    tick();
    tick();
    n_cmp++;
    if (o0.state !== 4'd12 || o0.illegal !== 1'b1 || o0.PCWrite !== 1'b0 || o0.IRWrite !== 1'b0 ||
        o0.MemWrite !== 1'b0 || o0.RegWrite !== 1'b0 || o0.instr_done !== 1'b0) begin
      n_bad++;
      $display("FAIL trap_hold: state=%0d ill=%b PC=%b IR=%b MW=%b RW=%b done=%b, need 12 1 0 0 0 0 0",
               o0.state, o0.illegal, o0.PCWrite, o0.IRWrite, o0.MemWrite, o0.RegWrite, o0.instr_done);
    end
    do_reset();
    op = 7'b0110111;
    tick();
    tick();
    n_cmp++;
    if (o2.state !== 4'd12 || o2.illegal !== 1'b1 || o0.state !== 4'd11 || o0.illegal !== 1'b0) begin
      n_bad++;
      $display("FAIL lui_disabled: nolui state=%0d ill=%b lui state=%0d ill=%b, need 12 1 11 0",
               o2.state, o2.illegal, o0.state, o0.illegal);
    end
  endtask
  task automatic test_reset_mid_write();
    do_reset();
    op = 7'b0100011;
    mem_ready = 1'b1;
    tick();
    tick();
    mem_ready = 1'b0;
    tick();
    n_cmp++;
    if (o0.state !== 4'd5 || o0.MemWrite !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_write_setup: state=%0d MW=%b, need 5 1", o0.state, o0.MemWrite);
    end
    mem_ready = 1'b1;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (o0.MemWrite !== 1'b0 || o0.state !== 4'd0 || o0.illegal !== 1'b0 || o0.IRWrite !== 1'b0 ||
        o0.PCWrite !== 1'b0 || o0.instr_done !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_write_reset: MW=%b state=%0d ill=%b IR=%b PC=%b done=%b, need 0 0 0 0 0 0",
               o0.MemWrite, o0.state, o0.illegal, o0.IRWrite, o0.PCWrite, o0.instr_done);
    end
    tick();
    reset = 1'b0;
    #1;
    tick();
    n_cmp++;
    if (o0.state !== 4'd1) begin
      n_bad++;
      $display("FAIL restart_fetch: state=%0d, need 1", o0.state);
    end
  endtask
  initial begin
    test_reset();
    test_rtype();
    test_lw();
    test_beq();
    test_sw();
    test_jal_lui();
    test_illegal();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter SUPPORT_LUI, default 1: when 1, opcode 0110111 (lui) is decoded; when 0, it is illegal.
REQ-002 Parameter TRAP_ON_ILLEGAL, default 1: when 1, an illegal opcode enters TRAP; when 0, it is skipped as a NOP.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 op  input  7  opcode field of the instruction register.
REQ-007 Zero  input  1  ALU zero flag.
REQ-008 mem_ready  input  1  memory access completes this cycle.
REQ-009 PCWrite  output  1  PC register enable.
REQ-010 AdrSrc  output  1  0 = PC address, 1 = ALU result address.
REQ-011 MemWrite, IRWrite, RegWrite  output  1 each  write enables.
REQ-012 ResultSrc, ALUSrcA, ALUSrcB, ALUOp  output  2 each  datapath selects.
REQ-013 ImmSrc  output  3  immediate format.
REQ-014 instr_done  output  1  one-cycle retire pulse.
REQ-015 illegal  output  1  sticky illegal-opcode flag.
REQ-016 state  output  4  current state code, for debug.

Function
REQ-017 State codes: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10, LUI=11, TRAP=12; codes 13-15 go to FETCH on the next edge.
REQ-018 Transitions:
- FETCH->DECODE only when mem_ready=1; otherwise hold.
- DECODE by op: 0000011/0100011->MEMADR; 0110011->EXECUTER; 0010011->EXECUTEI; 1100011->BEQ; 1101111->JAL; 0110111->LUI (SUPPORT_LUI=1); any other op->TRAP or FETCH per TRAP_ON_ILLEGAL.
- MEMADR->MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD->MEMWB, and MEMWRITE->FETCH, only when mem_ready=1; otherwise hold.
- MEMWB->FETCH; EXECUTER/EXECUTEI/JAL/LUI->ALUWB; ALUWB->FETCH; BEQ->FETCH.
- TRAP holds until reset.
REQ-019 Outputs not listed for a state SHALL be 0; ImmSrc is the exception (REQ-020). Per-state outputs:
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; IRWrite=1 and PCWrite=1 only in the cycle mem_ready=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
- MEMREAD: AdrSrc=1, ResultSrc=00.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: AdrSrc=1, MemWrite=1, held every cycle until mem_ready=1.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: ResultSrc=00, RegWrite=1.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00; PCWrite=Zero (combinational, same cycle).
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1.
- LUI: ALUSrcA=11 (zero operand), ALUSrcB=01, ALUOp=00.
- TRAP: all enables 0.
REQ-020 ImmSrc is combinational from op in every state: lw/I-type 000, sw 001, beq 010, jal 011, lui 100, otherwise 000.
REQ-021 instr_done=1 for exactly the one cycle in which the state leaves MEMWB, MEMWRITE (with mem_ready=1), ALUWB or BEQ toward FETCH, and in the DECODE cycle of a skipped illegal opcode.
REQ-022 illegal is registered: it is set on the edge DECODE decodes an illegal op, then stays 1 until reset.
REQ-023 mem_ready in a non-memory state is ignored.

Reset
REQ-024 While reset=1: state=FETCH (0), illegal=0, and every enable (PCWrite, IRWrite, MemWrite, RegWrite) and instr_done is 0, regardless of mem_ready.
REQ-025 Reset asserted in any state, including mid-wait, aborts the instruction with no further write enables; after release, execution starts in FETCH.

Verification
REQ-026 R-type op=0110011, mem_ready=1 -> states 0,1,6,8,0; RegWrite=1 only in state 8; instr_done pulses once; 4 cycles.
REQ-027 lw op=0000011, mem_ready low for 3 cycles in MEMREAD -> state holds 3 for 4 cycles, then 4 then 0; RegWrite=1 only in 4.
REQ-028 beq op=1100011: Zero=1 -> PCWrite=1 in state 9; Zero=0 -> PCWrite=0; both return to 0.
REQ-029 sw op=0100011, mem_ready=0 for 2 cycles -> MemWrite=1 for 3 consecutive cycles in state 5, then FETCH.
REQ-030 op=0000000: TRAP_ON_ILLEGAL=1 -> state 12 held and illegal=1; TRAP_ON_ILLEGAL=0 -> back to 0 with instr_done=1; SUPPORT_LUI=0 with op=0110111 -> treated as illegal.
REQ-031 Reset asserted mid-MEMWRITE -> MemWrite drops immediately; state=0; illegal=0.
